// File: rtl/rh_hammer_engine_if.sv
// Memory injection port of the rowhammer engine: registered request with a
// single-cycle ack; read data is valid in the ack cycle.
interface rh_hammer_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 64
);
  logic                  mem_req;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/rh_hammer_engine.sv
// Rowhammer sequencer: fills a victim row with a pattern, hammers its neighbour
// rows, then reads the victim back and accumulates flip statistics.
module rh_hammer_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 64,
  parameter int ROW_WIDTH  = 12,
  parameter int ROW_POS    = 10,
  parameter int COL_WIDTH  = 10,
  parameter int COL_POS    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] pattern,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  input  logic [31:0]           hammer_count,
  input  logic [1:0]            aggr_mode,
  rh_hammer_engine_if.master    mem,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            state,
  output logic [63:0]           bit_flip_count,
  output logic [COL_WIDTH:0]    flip_words,
  output logic [ADDR_WIDTH-1:0] first_flip_addr
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT   = 4'd1,
    S_HAMMER = 4'd2,
    S_READ   = 4'd3,
    S_DONE   = 4'd4
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] pattern_q, pattern_d;
  logic [ADDR_WIDTH-1:0] victim_q, victim_d;
  logic [31:0]           hcount_q, hcount_d;
  logic [1:0]            mode_q, mode_d;
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic [1:0]            aggr_idx_q, aggr_idx_d;
  logic [31:0]           round_q, round_d;
  logic                  req_q, req_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]           bfc_q, bfc_d;
  logic [COL_WIDTH:0]    fw_q, fw_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;

  logic                  fire;
  logic [63:0]           flips;

  function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [ROW_WIDTH-1:0]  row,
                                                      input logic [COL_WIDTH-1:0]  col);
    logic [ADDR_WIDTH-1:0] a;
    a = base;
    a[ROW_POS +: ROW_WIDTH] = row;
    a[COL_POS +: COL_WIDTH] = col;
    return a;
  endfunction

  // Offset selector: 0=-2, 1=-1, 2=+1, 3=+2; reserved mode behaves as double.
  function automatic logic [1:0] aggr_sel(input logic [1:0] mode, input logic [1:0] idx);
    case (mode)
      2'd0:    return 2'd2;
      2'd2:    return idx;
      default: return (idx == 2'd0) ? 2'd1 : 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] aggr_last(input logic [1:0] mode);
    case (mode)
      2'd0:    return 2'd0;
      2'd2:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] aggr_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [1:0]            sel);
    logic [ROW_WIDTH-1:0] row;
    row = base[ROW_POS +: ROW_WIDTH];
    case (sel)
      2'd0:    row = row - ROW_WIDTH'(2);
      2'd1:    row = row - ROW_WIDTH'(1);
      2'd2:    row = row + ROW_WIDTH'(1);
      default: row = row + ROW_WIDTH'(2);
    endcase
    return make_addr(base, row, '0);
  endfunction

  function automatic logic [63:0] popcount(input logic [WORD_WIDTH-1:0] v);
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < WORD_WIDTH; i++) c = c + 64'(v[i]);
    return c;
  endfunction

  assign fire  = req_q && mem.mem_ack;
  assign flips = popcount(pattern_q ^ mem.mem_rdata);

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    victim_d   = victim_q;
    hcount_d   = hcount_q;
    mode_d     = mode_q;
    col_d      = col_q;
    aggr_idx_d = aggr_idx_q;
    round_d    = round_q;
    req_d      = req_q;
    write_d    = write_q;
    addr_d     = addr_q;
    bfc_d      = bfc_q;
    fw_d       = fw_q;
    first_d    = first_q;

    if (abort && (state_q == S_INIT || state_q == S_HAMMER || state_q == S_READ)) begin
      // A coincident ack is dropped on the floor together with the test.
      state_d = S_IDLE;
      req_d   = 1'b0;
      write_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d    = S_INIT;
            pattern_d  = pattern;
            victim_d   = victim_addr;
            hcount_d   = hammer_count;
            mode_d     = aggr_mode;
            col_d      = '0;
            aggr_idx_d = '0;
            round_d    = '0;
            req_d      = 1'b1;
            write_d    = 1'b1;
            addr_d     = make_addr(victim_addr, victim_addr[ROW_POS +: ROW_WIDTH], '0);
            bfc_d      = '0;
            fw_d       = '0;
            first_d    = '0;
          end
        end
        S_INIT: begin
          if (fire) begin
            if (col_q == '1) begin
              col_d   = '0;
              write_d = 1'b0;
              if (hcount_q == '0) begin
                state_d = S_READ;
                addr_d  = make_addr(victim_q, victim_q[ROW_POS +: ROW_WIDTH], '0);
              end else begin
                state_d    = S_HAMMER;
                aggr_idx_d = '0;
                addr_d     = aggr_addr(victim_q, aggr_sel(mode_q, 2'd0));
              end
            end else begin
              col_d  = col_q + COL_WIDTH'(1);
              addr_d = make_addr(victim_q, victim_q[ROW_POS +: ROW_WIDTH], col_q + COL_WIDTH'(1));
            end
          end
        end
        S_HAMMER: begin
          if (fire) begin
            if (aggr_idx_q == aggr_last(mode_q)) begin
              round_d    = round_q + 32'd1;
              aggr_idx_d = '0;
              if (round_q + 32'd1 == hcount_q) begin
                state_d = S_READ;
                addr_d  = make_addr(victim_q, victim_q[ROW_POS +: ROW_WIDTH], '0);
              end else begin
                addr_d = aggr_addr(victim_q, aggr_sel(mode_q, 2'd0));
              end
            end else begin
              aggr_idx_d = aggr_idx_q + 2'd1;
              addr_d     = aggr_addr(victim_q, aggr_sel(mode_q, aggr_idx_q + 2'd1));
            end
          end
        end
        S_READ: begin
          if (fire) begin
            bfc_d = bfc_q + flips;
            if (flips != '0) begin
              fw_d = fw_q + (COL_WIDTH+1)'(1);
              if (fw_q == '0) first_d = addr_q;
            end
            if (col_q == '1) begin
              state_d = S_DONE;
              req_d   = 1'b0;
            end else begin
              col_d  = col_q + COL_WIDTH'(1);
              addr_d = make_addr(victim_q, victim_q[ROW_POS +: ROW_WIDTH], col_q + COL_WIDTH'(1));
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      victim_q   <= '0;
      hcount_q   <= '0;
      mode_q     <= '0;
      col_q      <= '0;
      aggr_idx_q <= '0;
      round_q    <= '0;
      req_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      bfc_q      <= '0;
      fw_q       <= '0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      victim_q   <= victim_d;
      hcount_q   <= hcount_d;
      mode_q     <= mode_d;
      col_q      <= col_d;
      aggr_idx_q <= aggr_idx_d;
      round_q    <= round_d;
      req_q      <= req_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      bfc_q      <= bfc_d;
      fw_q       <= fw_d;
      first_q    <= first_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_write = write_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = pattern_q;

  assign state           = state_q;
  assign busy            = (state_q == S_INIT) || (state_q == S_HAMMER) || (state_q == S_READ);
  assign done            = (state_q == S_DONE);
  assign bit_flip_count  = bfc_q;
  assign flip_words      = fw_q;
  assign first_flip_addr = first_q;

endmodule

// File: tb/tb_rh_hammer_engine.sv
// Directed bench for rh_hammer_engine with a 4-word row; a responder process
// plays the memory, logs accepted requests and injects flips and stalls.
module tb_rh_hammer_engine;
  localparam int AW = 32;
  localparam int WW = 64;
  localparam logic [WW-1:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] pattern = '0;
  logic [AW-1:0] victim_addr = '0;
  logic [31:0]   hammer_count = '0;
  logic [1:0]    aggr_mode = '0;
  logic          busy, done;
  logic [3:0]    state;
  logic [63:0]   bit_flip_count;
  logic [2:0]    flip_words;
  logic [AW-1:0] first_flip_addr;

  rh_hammer_engine_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) mem_if ();

  rh_hammer_engine #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .ROW_WIDTH(12), .ROW_POS(10), .COL_WIDTH(2), .COL_POS(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .pattern(pattern),
    .victim_addr(victim_addr), .hammer_count(hammer_count), .aggr_mode(aggr_mode),
    .mem(mem_if), .busy(busy), .done(done), .state(state), .bit_flip_count(bit_flip_count),
    .flip_words(flip_words), .first_flip_addr(first_flip_addr)
  );

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } txn_t;

  txn_t log_q[$];
  txn_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int            stall_max = 0;
  int            stall_cnt = 0;
  int            stab_err = 0;
  logic [3:0]    flip_cols = '0;
  logic [WW-1:0] flip_xor = '0;
  bit            cand_v = 1'b0;
  bit            pend = 1'b0;
  txn_t          cand, prev;

  // Memory responder, active just after each rising edge.
  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (cand_v && abort === 1'b0 && reset_n === 1'b1) log_q.push_back(cand);
      if (pend && abort === 1'b0 && reset_n === 1'b1 &&
          (mem_if.mem_req !== 1'b1 || mem_if.mem_write !== prev.w ||
           mem_if.mem_addr !== prev.a || mem_if.mem_wdata !== prev.d))
        stab_err++;
      if (stall_max == 0) mem_if.mem_ack = 1'b1;
      else if (mem_if.mem_req !== 1'b1) mem_if.mem_ack = 1'b0;
      else if (stall_cnt > 0) begin
        mem_if.mem_ack = 1'b0;
        stall_cnt--;
      end else begin
        mem_if.mem_ack = 1'b1;
        stall_cnt = $urandom_range(0, stall_max);
      end
      mem_if.mem_rdata = pattern ^ (flip_cols[mem_if.mem_addr[1:0]] ? flip_xor : '0);
      cand_v = (mem_if.mem_req === 1'b1) && (mem_if.mem_ack === 1'b1);
      pend   = (mem_if.mem_req === 1'b1) && (mem_if.mem_ack !== 1'b1);
      cand.w = mem_if.mem_write;
      cand.a = mem_if.mem_addr;
      cand.d = mem_if.mem_wdata;
      prev   = cand;
    end
  end

  task automatic do_start(input logic [WW-1:0] pat, input logic [AW-1:0] va,
                          input logic [31:0] hc, input logic [1:0] mode);
    @(negedge clk);
    pattern = pat; victim_addr = va; hammer_count = hc; aggr_mode = mode;
    log_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_read_col(input logic [1:0] col, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (state === 4'd3 && mem_if.mem_addr[1:0] === col) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Expected request sequence: 4 writes, hc rounds of the listed aggressor rows, 4 reads.
  task automatic exp_run(input logic [9:0] up, input logic [11:0] vrow, input logic [7:0] mid,
                         input logic [WW-1:0] pat, input int hc, input int n,
                         input logic [11:0] g0, input logic [11:0] g1,
                         input logic [11:0] g2, input logic [11:0] g3);
    logic [11:0] g [4];
    txn_t t;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      t.w = 1'b1; t.a = {up, vrow, mid, 2'(c)}; t.d = pat; exp_q.push_back(t);
    end
    for (int r = 0; r < hc; r++)
      for (int k = 0; k < n; k++) begin
        t.w = 1'b0; t.a = {up, g[k], mid, 2'b00}; t.d = pat; exp_q.push_back(t);
      end
    for (int c = 0; c < 4; c++) begin
      t.w = 1'b0; t.a = {up, vrow, mid, 2'(c)}; t.d = pat; exp_q.push_back(t);
    end
  endtask

  task automatic test_reset;
    #2;
    vectors++;
    if (state !== 4'd0 || mem_if.mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: state=%0d req=%b busy=%b done=%b, required 0 0 0 0", state, mem_if.mem_req, busy, done);
    end
    vectors++;
    if (bit_flip_count !== 64'd0 || flip_words !== 3'd0 || first_flip_addr !== '0 || mem_if.mem_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_results: bfc=%0d fw=%0d first=%h addr=%h, required all 0", bit_flip_count, flip_words, first_flip_addr, mem_if.mem_addr);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (state !== 4'd0 || mem_if.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack_ignored: state=%0d req=%b, required 0 0", state, mem_if.mem_req);
    end
    $display("reset: state=%0d req=%b", state, mem_if.mem_req);
  endtask

  task automatic test_basic;
    bit ok;
    flip_cols = '0; flip_xor = '0; stall_max = 0;
    exp_run(10'h201, 12'h123, 8'hBC, PAT, 3, 2, 12'h122, 12'h124, 12'h0, 12'h0);
    do_start(PAT, {10'h201, 12'h123, 8'hBC, 2'd3}, 32'd3, 2'd1);
    wait_done(200, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_timeout: done=%b required 1", done); end
    vectors++;
    if (log_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL basic_count: txns=%0d required %0d", log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i].w !== exp_q[i].w || log_q[i].a !== exp_q[i].a || (exp_q[i].w && log_q[i].d !== exp_q[i].d)) begin
        miscompares++;
        $display("FAIL basic_txn%0d: w=%b addr=%h data=%h, required w=%b addr=%h data=%h", i, log_q[i].w, log_q[i].a, log_q[i].d, exp_q[i].w, exp_q[i].a, exp_q[i].d);
      end
    end
    vectors++;
    if (bit_flip_count !== 64'd0 || flip_words !== 3'd0 || first_flip_addr !== '0 || state !== 4'd4 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: bfc=%0d fw=%0d first=%h state=%0d busy=%b, required 0 0 0 4 0", bit_flip_count, flip_words, first_flip_addr, state, busy);
    end
    $display("basic: txns=%0d bfc=%0d done=%b", log_q.size(), bit_flip_count, done);
  endtask

  task automatic test_flip;
    bit ok;
    flip_cols = 4'b0100; flip_xor = 64'h5; stall_max = 0;
    do_start(PAT, {10'h201, 12'h123, 8'hBC, 2'd3}, 32'd3, 2'd1);
    wait_done(200, ok);
    vectors++;
    if (ok !== 1'b1 || bit_flip_count !== 64'd2 || flip_words !== 3'd1 ||
        first_flip_addr !== {10'h201, 12'h123, 8'hBC, 2'd2}) begin
      miscompares++;
      $display("FAIL flip_col2: done=%b bfc=%0d fw=%0d first=%h, required 1 2 1 %h", ok, bit_flip_count, flip_words, first_flip_addr, {10'h201, 12'h123, 8'hBC, 2'd2});
    end
    $display("flip: bfc=%0d fw=%0d first=%h", bit_flip_count, flip_words, first_flip_addr);
  endtask

  task automatic test_quad_wrap;
    bit ok;
    flip_cols = '0; flip_xor = '0; stall_max = 0;
    exp_run(10'h3FF, 12'h001, 8'hFF, PAT, 2, 4, 12'hFFF, 12'h000, 12'h002, 12'h003);
    do_start(PAT, {10'h3FF, 12'h001, 8'hFF, 2'd0}, 32'd2, 2'd2);
    wait_done(200, ok);
    vectors++;
    if (ok !== 1'b1 || log_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL quad_count: done=%b txns=%0d required 1 %0d", ok, log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i].w !== exp_q[i].w || log_q[i].a !== exp_q[i].a) begin
        miscompares++;
        $display("FAIL quad_txn%0d: w=%b addr=%h, required w=%b addr=%h", i, log_q[i].w, log_q[i].a, exp_q[i].w, exp_q[i].a);
      end
    end
    $display("quad: txns=%0d", log_q.size());
  endtask

  task automatic test_single_full_row;
    bit ok;
    flip_cols = 4'b1111; flip_xor = '1; stall_max = 0;
    exp_run(10'h155, 12'hFFF, 8'h5A, 64'h0123_4567_89AB_CDEF, 2, 1, 12'h000, 12'h0, 12'h0, 12'h0);
    do_start(64'h0123_4567_89AB_CDEF, {10'h155, 12'hFFF, 8'h5A, 2'd2}, 32'd2, 2'd0);
    wait_done(200, ok);
    vectors++;
    if (ok !== 1'b1 || log_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL single_count: done=%b txns=%0d required 1 %0d", ok, log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i].w !== exp_q[i].w || log_q[i].a !== exp_q[i].a || (exp_q[i].w && log_q[i].d !== exp_q[i].d)) begin
        miscompares++;
        $display("FAIL single_txn%0d: w=%b addr=%h, required w=%b addr=%h", i, log_q[i].w, log_q[i].a, exp_q[i].w, exp_q[i].a);
      end
    end
    vectors++;
    if (bit_flip_count !== 64'd256 || flip_words !== 3'd4 || first_flip_addr !== {10'h155, 12'hFFF, 8'h5A, 2'd0}) begin
      miscompares++;
      $display("FAIL full_row_flips: bfc=%0d fw=%0d first=%h, required 256 4 %h", bit_flip_count, flip_words, first_flip_addr, {10'h155, 12'hFFF, 8'h5A, 2'd0});
    end
    $display("single_full_row: bfc=%0d fw=%0d", bit_flip_count, flip_words);
  endtask

  task automatic test_reserved_mode;
    bit ok;
    flip_cols = '0; flip_xor = '0; stall_max = 0;
    exp_run(10'h0AA, 12'h000, 8'h00, PAT, 1, 2, 12'hFFF, 12'h001, 12'h0, 12'h0);
    do_start(PAT, {10'h0AA, 12'h000, 8'h00, 2'd1}, 32'd1, 2'd3);
    wait_done(200, ok);
    vectors++;
    if (ok !== 1'b1 || log_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL mode3_count: done=%b txns=%0d required 1 %0d", ok, log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i].w !== exp_q[i].w || log_q[i].a !== exp_q[i].a) begin
        miscompares++;
        $display("FAIL mode3_txn%0d: w=%b addr=%h, required w=%b addr=%h", i, log_q[i].w, log_q[i].a, exp_q[i].w, exp_q[i].a);
      end
    end
    $display("mode3: txns=%0d", log_q.size());
  endtask

  task automatic test_stall;
    bit ok;
    for (int s = 0; s < 2; s++) begin
      flip_cols = 4'b1010; flip_xor = 64'hF000_0000_0000_0001;
      stall_max = (s == 0) ? 0 : 5; stall_cnt = 0; stab_err = 0;
      exp_run(10'h201, 12'h123, 8'hBC, PAT, 2, 4, 12'h121, 12'h122, 12'h124, 12'h125);
      do_start(PAT, {10'h201, 12'h123, 8'hBC, 2'd3}, 32'd2, 2'd2);
      wait_done(1000, ok);
      vectors++;
      if (ok !== 1'b1 || log_q.size() !== exp_q.size()) begin
        miscompares++; $display("FAIL stall%0d_count: done=%b txns=%0d required 1 %0d", s, ok, log_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < log_q.size()) begin
        vectors++;
        if (log_q[i].w !== exp_q[i].w || log_q[i].a !== exp_q[i].a || (exp_q[i].w && log_q[i].d !== exp_q[i].d)) begin
          miscompares++;
          $display("FAIL stall%0d_txn%0d: w=%b addr=%h, required w=%b addr=%h", s, i, log_q[i].w, log_q[i].a, exp_q[i].w, exp_q[i].a);
        end
      end
      vectors++;
      if (stab_err !== 0) begin
        miscompares++; $display("FAIL stall%0d_stable: unstable_cycles=%0d required 0", s, stab_err);
      end
      vectors++;
      if (bit_flip_count !== 64'd10 || flip_words !== 3'd2 || first_flip_addr !== {10'h201, 12'h123, 8'hBC, 2'd1}) begin
        miscompares++;
        $display("FAIL stall%0d_result: bfc=%0d fw=%0d first=%h, required 10 2 %h", s, bit_flip_count, flip_words, first_flip_addr, {10'h201, 12'h123, 8'hBC, 2'd1});
      end
      $display("stall%0d: txns=%0d bfc=%0d fw=%0d", s, log_q.size(), bit_flip_count, flip_words);
    end
    stall_max = 0;
  endtask

  task automatic test_zero_hammer;
    bit ok;
    flip_cols = '0; flip_xor = '0; stall_max = 0;
    exp_run(10'h201, 12'h123, 8'hBC, PAT, 0, 2, 12'h0, 12'h0, 12'h0, 12'h0);
    do_start(PAT, {10'h201, 12'h123, 8'hBC, 2'd3}, 32'd0, 2'd1);
    wait_done(200, ok);
    vectors++;
    if (ok !== 1'b1 || log_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL zero_count: done=%b txns=%0d required 1 %0d", ok, log_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < log_q.size()) begin
      vectors++;
      if (log_q[i].w !== exp_q[i].w || log_q[i].a !== exp_q[i].a) begin
        miscompares++;
        $display("FAIL zero_txn%0d: w=%b addr=%h, required w=%b addr=%h", i, log_q[i].w, log_q[i].a, exp_q[i].w, exp_q[i].a);
      end
    end
    vectors++;
    if (bit_flip_count !== 64'd0 || flip_words !== 3'd0 || first_flip_addr !== '0) begin
      miscompares++;
      $display("FAIL zero_cleared: bfc=%0d fw=%0d first=%h, required 0 0 0", bit_flip_count, flip_words, first_flip_addr);
    end
    $display("zero_hammer: txns=%0d", log_q.size());
  endtask

  task automatic test_abort_and_reset;
    bit ok;
    flip_cols = '0; flip_xor = '0; stall_max = 0;
    do_start(PAT, {10'h201, 12'h123, 8'hBC, 2'd3}, 32'd100, 2'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (state === 4'd2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    vectors++;
    if (ok !== 1'b1 || state !== 4'd0 || mem_if.mem_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_hammer: reached=%b state=%0d req=%b done=%b busy=%b, required 1 0 0 0 0", ok, state, mem_if.mem_req, done, busy);
    end

    flip_cols = 4'b1111; flip_xor = 64'h1;
    do_start(PAT, {10'h201, 12'h123, 8'hBC, 2'd3}, 32'd0, 2'd1);
    wait_read_col(2'd1, 50, ok);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    vectors++;
    if (ok !== 1'b1 || state !== 4'd0 || done !== 1'b0 || bit_flip_count !== 64'd1 || flip_words !== 3'd1 ||
        first_flip_addr !== {10'h201, 12'h123, 8'hBC, 2'd0}) begin
      miscompares++;
      $display("FAIL abort_read: reached=%b state=%0d done=%b bfc=%0d fw=%0d first=%h, required 1 0 0 1 1 %h", ok, state, done, bit_flip_count, flip_words, first_flip_addr, {10'h201, 12'h123, 8'hBC, 2'd0});
    end
    $display("abort: state=%0d bfc=%0d fw=%0d", state, bit_flip_count, flip_words);

    do_start(PAT, {10'h201, 12'h123, 8'hBC, 2'd3}, 32'd0, 2'd1);
    wait_read_col(2'd2, 50, ok);
    vectors++;
    if (ok !== 1'b1 || bit_flip_count !== 64'd2) begin
      miscompares++; $display("FAIL pre_reset_read: reached=%b bfc=%0d, required 1 2", ok, bit_flip_count);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (mem_if.mem_req !== 1'b0 || mem_if.mem_write !== 1'b0 || mem_if.mem_addr !== '0 || state !== 4'd0 ||
        done !== 1'b0 || busy !== 1'b0 || bit_flip_count !== 64'd0 || flip_words !== 3'd0 || first_flip_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_read: req=%b state=%0d done=%b bfc=%0d fw=%0d first=%h, required all 0", mem_if.mem_req, state, done, bit_flip_count, flip_words, first_flip_addr);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (state !== 4'd0 || mem_if.mem_req !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: state=%0d req=%b, required 0 0", state, mem_if.mem_req);
    end
    $display("reset_mid_read: state=%0d req=%b", state, mem_if.mem_req);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_quad_wrap();
    test_single_full_row();
    test_reserved_mode();
    test_stall();
    test_zero_hammer();
    test_abort_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
